mdu_ctrl: RTL

- Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs multi-cycle operations in the background.
- Raises a stall request so the IF/ID/ID_EX/EX_MEM pipeline registers freeze while a HI/LO consumer waits.
- Drives HI/LO values forward into EX_MEM's HILO path.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_div_iter.sv | 32 +++
 rtl/mdu_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDU opcode encoding as presented by the EX stage (OP_NONE..OP_MADDU)
//   - controller state encoding (IDLE, MUL, DIV, FIX)
//   - divide iteration count and the width of the shared latency counter
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

    typedef logic [1:0] mdu_state_t;

    localparam mdu_state_t ST_IDLE = 2'd0;
    localparam mdu_state_t ST_MUL  = 2'd1;
    localparam mdu_state_t ST_DIV  = 2'd2;
    localparam mdu_state_t ST_FIX  = 2'd3;

    localparam int DIV_ITERS = 32;

    // One counter serves both the multiply latency (up to 15, or 16 with
    // accumulate) and the 32 divide iterations.
    localparam int CNT_W = $clog2(DIV_ITERS);

endpackage

// File: rtl/mdu_div_iter.sv
// mdu_div_iter: one radix-2 restoring division step.
//   rem      in   current partial remainder
//   quo      in   dividend bits not yet consumed (MSB first) / quotient so far
//   divisor  in   divisor magnitude
//   rem_next out  partial remainder after this step
//   quo_next out  quo shifted left with the new quotient bit in the LSB
// With divisor=0 every trial subtraction succeeds, so after WIDTH steps the
// quotient is all ones and the remainder is the dividend.
module mdu_div_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_sh;
    logic           fits;

    assign rem_sh = {rem, quo[WIDTH-1]};
    assign fits   = (rem_sh >= {1'b0, divisor});

    // When the divisor fits the true difference is below the divisor, so the
    // low WIDTH bits of the subtraction are exact.
    assign rem_next = fits ? (rem_sh[WIDTH-1:0] - divisor) : rem_sh[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU accumulate into {HI,LO}).
// Ports:
//   clk         in   pipeline clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start_i     in   EX stage holds an MDU op this cycle
//   op_i        in   MDU opcode (see mdu_pkg)
//   rs_i, rt_i  in   forwarded operands
//   use_hilo_i  in   EX instruction reads or writes HI/LO
//   flush_i     in   EX stage squashed; aborts any in-flight operation
//   busy_o      out  operation in flight
//   stall_o     out  pipeline freeze request (HI/LO consumer while busy)
//   hi_o, lo_o  out  architectural HI/LO
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic             use_hilo_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int PW = 2 * WIDTH;

    mdu_state_t       state;
    logic [CNT_W-1:0] cnt;

    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             neg_quo;
    logic             neg_rem;

    logic             accept;
    logic             mul_signed;
    logic             div_signed;
    logic [PW-1:0]    mul_a;
    logic [PW-1:0]    mul_b;
    logic [PW-1:0]    mul_full;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;

`ifdef MDU_MADD_EN
    logic             acc;
`endif

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign accept = (state == ST_IDLE) & start_i & ~flush_i;

`ifdef MDU_MADD_EN
    assign mul_signed = (op_i == OP_MULT) | (op_i == OP_MADD);
`else
    assign mul_signed = (op_i == OP_MULT);
`endif
    assign div_signed = (op_i == OP_DIV);

    // Extending to the full product width makes the truncated product the
    // correct 64-bit result for both signed and unsigned operands.
    assign mul_a    = {{WIDTH{mul_signed & rs_i[WIDTH-1]}}, rs_i};
    assign mul_b    = {{WIDTH{mul_signed & rt_i[WIDTH-1]}}, rt_i};
    assign mul_full = mul_a * mul_b;

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    assign rs_mag = magnitude(rs_i, div_signed);
    assign rt_mag = magnitude(rt_i, div_signed);

    assign busy_o  = (state != ST_IDLE);
    assign stall_o = use_hilo_i & busy_o;

    mdu_div_iter #(
        .WIDTH    (WIDTH)
    ) u_div_iter (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Operand/datapath registers: loaded on acceptance, stepped while dividing.
    // Their contents only matter once the FSM commits them, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            prod    <= mul_full;
            quo     <= rs_mag;
            rem     <= '0;
            divisor <= rt_mag;
            neg_quo <= div_signed & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
            neg_rem <= div_signed & rs_i[WIDTH-1];
        end else if (state == ST_DIV) begin
            rem <= rem_next;
            quo <= quo_next;
        end
    end

    // Sequencer and architectural HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hi_o  <= '0;
            lo_o  <= '0;
`ifdef MDU_MADD_EN
            acc   <= 1'b0;
`endif
        end else if (flush_i) begin
            // Squash wins over both a new start and a pending HI/LO commit.
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        case (op_i)
                            OP_MULT, OP_MULTU: begin
                                state <= ST_MUL;
                                cnt   <= CNT_W'(MUL_LAT - 1);
`ifdef MDU_MADD_EN
                                acc   <= 1'b0;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                state <= ST_DIV;
                                cnt   <= CNT_W'(DIV_ITERS - 1);
                            end
                            OP_MTHI: hi_o <= rs_i;
                            OP_MTLO: lo_o <= rs_i;
`ifdef MDU_MADD_EN
                            // One extra cycle for the 64-bit accumulate.
                            OP_MADD, OP_MADDU: begin
                                state <= ST_MUL;
                                cnt   <= CNT_W'(MUL_LAT);
                                acc   <= 1'b1;
                            end
`else
                            OP_MADD, OP_MADDU: ;
`endif
                            OP_NONE: ;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
`ifdef MDU_MADD_EN
                        if (acc) begin
                            {hi_o, lo_o} <= {hi_o, lo_o} + prod;
                        end else begin
                            {hi_o, lo_o} <= prod;
                        end
`else
                        {hi_o, lo_o} <= prod;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    lo_o  <= apply_sign(quo, neg_quo);
                    hi_o  <= apply_sign(rem, neg_rem);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
